// File: rtl/keypad_scan_ctrl_if.sv
// Key-code delivery bus between the keypad scanner and the management side.
// The master side presents FIFO status and the head code; the slave side pops and clears.
interface keypad_scan_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_ready;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          clr_overflow;

  modport master (
    output key_valid, key_code, fifo_count, overflow,
    input  key_ready, clr_overflow
  );

  modport slave (
    input  key_valid, key_code, fifo_count, overflow,
    output key_ready, clr_overflow
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 hex keypad scanner: column sequencing, row synchronising, press/release debounce,
// and a key-code FIFO popped over a valid/ready handshake.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        row_in,
  output logic [3:0]        col_out,
  keypad_scan_ctrl_if.master kbus
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DEB, S_HELD} state_t;

  state_t        state, state_n;
  logic [3:0]    sync1, rows_s, act;
  logic [1:0]    col_idx, col_n;
  logic [1:0]    cand_row, cand_row_n, cand_col, cand_col_n;
  logic [DW-1:0] div, div_n;
  logic [MW-1:0] match_cnt, match_n, rel_cnt, rel_n;
  logic          sample;
  logic          act_one;
  logic [1:0]    act_idx;
  logic          push;
  logic [3:0]    push_code;

  // Two-flop synchroniser; idle level of the pulled-up rows is all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '1;
      rows_s <= '1;
    end else begin
      sync1  <= row_in;
      rows_s <= sync1;
    end
  end

  assign act = ~rows_s;

  always_comb begin
    act_one = 1'b0;
    act_idx = '0;
    case (act)
      4'b0001: begin act_one = 1'b1; act_idx = 2'd0; end
      4'b0010: begin act_one = 1'b1; act_idx = 2'd1; end
      4'b0100: begin act_one = 1'b1; act_idx = 2'd2; end
      4'b1000: begin act_one = 1'b1; act_idx = 2'd3; end
      default: ;
    endcase
  end

  assign sample  = (state != S_IDLE) && (div == DW'(SCAN_DIV - 1));
  assign col_out = (state == S_IDLE) ? 4'b1111 : ~(4'b0001 << col_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      col_idx   <= '0;
      div       <= '0;
      match_cnt <= '0;
      rel_cnt   <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
    end else begin
      state     <= state_n;
      col_idx   <= col_n;
      div       <= div_n;
      match_cnt <= match_n;
      rel_cnt   <= rel_n;
      cand_row  <= cand_row_n;
      cand_col  <= cand_col_n;
    end
  end

  always_comb begin
    state_n    = state;
    col_n      = col_idx;
    div_n      = div;
    match_n    = match_cnt;
    rel_n      = rel_cnt;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    push       = 1'b0;
    push_code  = {cand_row, cand_col};

    if (state == S_IDLE) begin
      col_n   = '0;
      div_n   = '0;
      match_n = '0;
      rel_n   = '0;
      if (enable) state_n = S_SCAN;
    end else if (!enable) begin
      state_n = S_IDLE;
      col_n   = '0;
      div_n   = '0;
      match_n = '0;
      rel_n   = '0;
    end else begin
      div_n = sample ? '0 : div + 1'b1;
      if (sample) begin
        case (state)
          S_SCAN: begin
            if (act_one) begin
              cand_row_n = act_idx;
              cand_col_n = col_idx;
              match_n    = MW'(1);
              rel_n      = '0;
              if (DEBOUNCE == 1) begin
                push      = 1'b1;
                push_code = {act_idx, col_idx};
                state_n   = S_HELD;
              end else begin
                state_n = S_DEB;
              end
            end else begin
              col_n = col_idx + 2'd1;
            end
          end
          S_DEB: begin
            if (act == (4'b0001 << cand_row)) begin
              if (match_cnt == MW'(DEBOUNCE - 1)) begin
                push    = 1'b1;
                rel_n   = '0;
                state_n = S_HELD;
              end else begin
                match_n = match_cnt + 1'b1;
              end
            end else begin
              state_n = S_SCAN;
              col_n   = cand_col + 2'd1;
            end
          end
          S_HELD: begin
            // Any row activity restarts the release count, so a held key pushes once.
            if (act == '0) begin
              if (rel_cnt == MW'(DEBOUNCE - 1)) begin
                rel_n   = '0;
                state_n = S_SCAN;
                col_n   = cand_col + 2'd1;
              end else begin
                rel_n = rel_cnt + 1'b1;
              end
            end else begin
              rel_n = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, do_push, ovf_evt;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = kbus.key_valid & kbus.key_ready;
  // A pop frees the slot a same-cycle push into a full FIFO needs.
  assign do_push = push & (~full | pop);
  assign ovf_evt = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      kbus.overflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (ovf_evt)                kbus.overflow <= 1'b1;
      else if (kbus.clr_overflow) kbus.overflow <= 1'b0;
    end
  end

  assign kbus.key_valid  = (count != '0);
  assign kbus.key_code   = kbus.key_valid ? mem[rd_ptr] : '0;
  assign kbus.fifo_count = count;
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for a 4x4 hex keypad on user GPIO.
- Drives one column low at a time and samples the four row lines through a synchroniser.
- Debounces a single key press and encodes it as a 4-bit hex code.
- Queues codes in a small FIFO that the management side pops with a valid/ready handshake; the FIFO also feeds the wishbone/LA readback.

Parameters:
- SCAN_DIV, 16, clk cycles each column is driven; must be >= 4.
- DEBOUNCE, 4, consecutive identical samples needed to accept a press or a release; must be >= 1.
- FIFO_DEPTH, 4, key-code FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  scan enable; low forces IDLE.
- row_in  input  4  keypad rows, active-low, pulled up externally, asynchronous to clk.
- col_out  output  4  column drive, active-low, one-hot-low while scanning.
- key_valid  output  1  FIFO not empty.
- key_code  output  4  FIFO head code, meaningful when key_valid=1.
- key_ready  input  1  pop request; pop occurs when key_valid & key_ready.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  current number of FIFO entries.
- overflow  output  1  sticky flag: a code was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, registers clear immediately):
  - state=IDLE, col_out=4'b1111, col_idx=0, div counter=0.
  - FIFO empty: key_valid=0, fifo_count=0, key_code=0.
  - overflow=0, synchroniser flops=4'b1111.
- Synchroniser: row_in passes through 2 flops giving rows_s; active rows are act = ~rows_s.
- Column drive and sampling:
  - col_out = ~(4'b0001 << col_idx) in every state except IDLE.
  - The div counter counts 0..SCAN_DIV-1 and wraps.
  - A "sample" occurs on the cycle where div==SCAN_DIV-1.
- IDLE:
  - col_out=1111.
  - When enable=1, go to SCAN on the next edge with col_idx=0 and div=0.
- SCAN: at each sample:
  - If act has exactly one bit set: latch cand_row (index of the set bit) and cand_col=col_idx, set match_cnt=1, go to DEBOUNCE.
  - If DEBOUNCE=1, push immediately and go to HELD instead.
  - Zero bits set, or two or more bits set (ghost/multi-key): col_idx increments mod 4 (3 wraps to 0).
- DEBOUNCE: col_idx is held at cand_col. At each sample:
  - If act == one-hot(cand_row): match_cnt++. When it reaches DEBOUNCE, push code = 4*cand_row + cand_col and go to HELD.
  - Otherwise go to SCAN with col_idx = cand_col+1 mod 4. No push.
- HELD: column held. At each sample:
  - act==0: rel_cnt++, else rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE, go to SCAN with col_idx = cand_col+1 mod 4.
  - A held key produces exactly one push.
- enable=0 in any non-IDLE state:
  - Next edge: IDLE, col_out=1111, all counters cleared.
  - FIFO and overflow are retained.
  - A press in progress is discarded.
- FIFO:
  - Circular buffer; key_code is driven combinationally from the head entry.
  - pop only if key_valid; push is the internal accept event.
  - Push while not full: store the code, count+1.
  - Push while full with no pop: code dropped, overflow<=1, count unchanged.
  - Push and pop together while full: both happen, count unchanged, no overflow.
  - Push and pop together while empty: push only; key_valid rises the next cycle.
  - Pointers wrap mod FIFO_DEPTH.
- overflow:
  - clr_overflow=1 clears it.
  - If clr_overflow and an overflow event land in the same cycle, overflow ends set.
- Latency: rows stable from a sample produce a push at the DEBOUNCE-th matching sample; key_valid is high the following cycle.

Test Plan (SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4):
- Press row1/col2, held 200 cycles, then release:
  - Exactly one push; key_code=4'h6, fifo_count=1.
  - After pop: key_valid=0.
  - Scanning resumes on col 3 after 2 released samples.
- Bounce: row0 asserted at col0 for one sample, released on the next:
  - No push; fifo_count=0.
  - col_out continues 1101 after the bounce.
- Ghost: rows 0 and 3 both low while col1 is driven:
  - No push; col_idx keeps cycling 0→1→2→3→0.
- Overflow: five distinct presses (codes 0,5,A,F,3) with key_ready=0:
  - fifo_count=4, overflow=1, key_code=0.
  - Popping drains 0,5,A,F in order.
  - clr_overflow then gives overflow=0.
- Full FIFO with key_ready=1 held on the push cycle:
  - fifo_count stays 4, overflow=0.
  - Head advances to the next entry.
- Reset asserted mid-DEBOUNCE (async, between clk edges):
  - col_out=1111, key_valid=0, fifo_count=0 immediately.
  - After release with enable=1: scan restarts at col0 (col_out=1110).
